// File: rtl/sha3_digest_serializer_pkg.sv
// rtl/sha3_digest_serializer_pkg.sv - Keccak state width, digest mode encoding and serializer FSM states
package sha3_pkg;

  localparam int STATE_WIDTH = 1600;
  // Wide enough for the largest word count (512 bits in 16-bit words = 32).
  localparam int CNT_WIDTH   = 6;

  typedef enum logic [1:0] {
    MODE_224 = 2'b00,
    MODE_256 = 2'b01,
    MODE_384 = 2'b10,
    MODE_512 = 2'b11
  } sha3_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int digest_bits(input sha3_mode_t m);
    case (m)
      MODE_224: return 224;
      MODE_256: return 256;
      MODE_384: return 384;
      default:  return 512;
    endcase
  endfunction

endpackage

// File: rtl/sha3_digest_serializer_if.sv
// rtl/sha3_digest_serializer_if.sv - state capture and digest word stream signals of the serializer
interface sha3_digest_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  import sha3_pkg::*;

  logic [STATE_WIDTH-1:0] state_in;
  logic                   state_valid;
  logic                   state_ready;
  logic [1:0]             mode;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  logic                   busy;

  // master is the serializer itself; slave is the environment around it.
  modport master (
    input  state_in, state_valid, mode, m_ready,
    output state_ready, m_data, m_valid, m_last, busy
  );

  modport slave (
    output state_in, state_valid, mode, m_ready,
    input  state_ready, m_data, m_valid, m_last, busy
  );

endinterface

// File: rtl/sha3_digest_serializer.sv
// rtl/sha3_digest_serializer.sv - captures a final Keccak state and streams its digest MSB-first in DATA_WIDTH words
module sha3_digest_serializer
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      RST,
  sha3_digest_serializer_if.master  bus
);

  ser_state_t             state_q, state_d;
  logic [STATE_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]   cnt;
  sha3_mode_t             mode_q;
  logic                   capture, xfer;
  logic                   active, final_word;
  logic [DATA_WIDTH-1:0]  tail_mask;

  function automatic logic [CNT_WIDTH-1:0] word_count(input sha3_mode_t m);
    int n;
    n = (digest_bits(m) + DATA_WIDTH - 1) / DATA_WIDTH;
    return CNT_WIDTH'(n);
  endfunction

  // A digest that does not fill its last word keeps only its own bits in the MSBs.
  function automatic logic [DATA_WIDTH-1:0] final_mask(input sha3_mode_t m);
    int rem;
    logic [DATA_WIDTH-1:0] ones;
    rem  = digest_bits(m) % DATA_WIDTH;
    ones = '1;
    if (rem == 0) return ones;
    return ~(ones >> rem);
  endfunction

  always_ff @(posedge clk) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.state_valid) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          xfer = 1'b1;
          if (final_word) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      shreg  <= '0;
      cnt    <= '0;
      mode_q <= MODE_224;
    end else if (capture) begin
      shreg  <= bus.state_in;
      cnt    <= word_count(sha3_mode_t'(bus.mode));
      mode_q <= sha3_mode_t'(bus.mode);
    end else if (xfer) begin
      shreg  <= {shreg[STATE_WIDTH-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
      cnt    <= cnt - CNT_WIDTH'(1);
    end
  end

  // Outputs are gated by RST so an abort emits nothing in the reset cycle.
  assign active     = (state_q == SEND) && !RST;
  assign final_word = (cnt == CNT_WIDTH'(1));
  assign tail_mask  = final_word ? final_mask(mode_q) : '1;

  assign bus.state_ready = (state_q == IDLE) && !RST;
  assign bus.m_valid     = active;
  assign bus.busy        = active;
  assign bus.m_last      = active && final_word;
  assign bus.m_data      = shreg[STATE_WIDTH-1 -: DATA_WIDTH] & tail_mask;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb/tb_sha3_digest_serializer.sv - bench driving 16/32/64-bit serializers in lockstep against a digest-word model
module tb_sha3_digest_serializer;
  import sha3_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic [1599:0] state_in;
  logic          state_valid;
  logic          m_ready;
  logic [1:0]    mode;

  sha3_digest_serializer_if #(.DATA_WIDTH(16)) if16 ();
  sha3_digest_serializer_if #(.DATA_WIDTH(32)) if32 ();
  sha3_digest_serializer_if #(.DATA_WIDTH(64)) if64 ();

  assign if16.state_in = state_in; assign if16.state_valid = state_valid;
  assign if16.mode     = mode;     assign if16.m_ready     = m_ready;
  assign if32.state_in = state_in; assign if32.state_valid = state_valid;
  assign if32.mode     = mode;     assign if32.m_ready     = m_ready;
  assign if64.state_in = state_in; assign if64.state_valid = state_valid;
  assign if64.mode     = mode;     assign if64.m_ready     = m_ready;

  sha3_digest_serializer #(.DATA_WIDTH(16)) dut16 (.clk(clk), .RST(RST), .bus(if16));
  sha3_digest_serializer #(.DATA_WIDTH(32)) dut32 (.clk(clk), .RST(RST), .bus(if32));
  sha3_digest_serializer #(.DATA_WIDTH(64)) dut64 (.clk(clk), .RST(RST), .bus(if64));

  logic [63:0] dout [3];
  logic        dvalid [3], dlast [3], dready [3], dbusy [3];

  assign dout[0] = 64'(if16.m_data); assign dvalid[0] = if16.m_valid; assign dlast[0] = if16.m_last;
  assign dready[0] = if16.state_ready; assign dbusy[0] = if16.busy;
  assign dout[1] = 64'(if32.m_data); assign dvalid[1] = if32.m_valid; assign dlast[1] = if32.m_last;
  assign dready[1] = if32.state_ready; assign dbusy[1] = if32.busy;
  assign dout[2] = if64.m_data;      assign dvalid[2] = if64.m_valid; assign dlast[2] = if64.m_last;
  assign dready[2] = if64.state_ready; assign dbusy[2] = if64.busy;

  int          wid [3] = '{16, 32, 64};
  logic [63:0] exp_w [3][64];
  int          exp_n [3];
  int          exp_rd [3];
  bit          sending [3];
  logic [63:0] got [3][64];
  int          got_n [3];
  int          got_last_idx [3];
  int          total = 0;
  int          passed = 0;

  function automatic int dbits(input logic [1:0] m);
    case (m)
      2'b00:   return 224;
      2'b01:   return 256;
      2'b10:   return 384;
      default: return 512;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected words: the top digest bits of state_in, MSB first, zero-padded to whole words.
  task automatic build(input int k);
    int bits;
    int w;
    int pos;
    logic [63:0] word;
    bits = dbits(mode);
    w = wid[k];
    exp_n[k] = (bits + w - 1) / w;
    exp_rd[k] = 0;
    for (int i = 0; i < exp_n[k]; i++) begin
      word = '0;
      for (int b = 0; b < w; b++) begin
        pos = i * w + b;
        if (pos < bits) word[w-1-b] = state_in[1599-pos];
      end
      exp_w[k][i] = word;
    end
  endtask

  // Inputs are set before calling; outputs are compared, then one edge is taken.
  task automatic tick();
    bit ev;
    bit el;
    #1;
    for (int k = 0; k < 3; k++) begin
      ev = sending[k] && !RST;
      el = ev && (exp_n[k] - exp_rd[k] == 1);
      chk($sformatf("state_ready_w%0d", wid[k]), 64'(dready[k]), 64'(!sending[k] && !RST));
      chk($sformatf("m_valid_w%0d", wid[k]), 64'(dvalid[k]), 64'(ev));
      chk($sformatf("busy_w%0d", wid[k]), 64'(dbusy[k]), 64'(ev));
      chk($sformatf("m_last_w%0d", wid[k]), 64'(dlast[k]), 64'(el));
      if (ev) chk($sformatf("m_data_w%0d_word%0d", wid[k], exp_rd[k]), dout[k], exp_w[k][exp_rd[k]]);
      if (dvalid[k] && m_ready && got_n[k] < 64) begin
        got[k][got_n[k]] = dout[k];
        if (dlast[k]) got_last_idx[k] = got_n[k];
        got_n[k]++;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (RST) sending[k] = 1'b0;
      else if (!sending[k] && state_valid) begin
        build(k);
        sending[k] = 1'b1;
        got_n[k] = 0;
        got_last_idx[k] = -1;
      end else if (sending[k] && m_ready) begin
        exp_rd[k]++;
        if (exp_rd[k] == exp_n[k]) sending[k] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic start(input logic [1:0] md);
    mode = md;
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
  endtask

  task automatic run_idle(input string name, input bit toggle);
    int n;
    n = 0;
    while ((dbusy[0] || dbusy[1] || dbusy[2] || sending[0] || sending[1] || sending[2]) && n < 100) begin
      tick();
      if (toggle) m_ready = ~m_ready;
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < 100), 64'd1);
    m_ready = 1'b1;
    tick();
  endtask

  task automatic pat_a();
    state_in = {400{4'h5}};
    for (int i = 0; i < 16; i++) state_in[1599-16*i -: 16] = 16'(16'hA000 + i);
  endtask

  initial begin
    RST = 1'b1; state_valid = 1'b0; m_ready = 1'b0; mode = 2'b00; state_in = '0;
    tick(); tick();
    RST = 1'b0;
    tick();

    // 256-bit digest, continuous ready
    pat_a(); m_ready = 1'b1;
    start(2'b01);
    run_idle("t1", 1'b0);
    chk("t1_count_w16", 64'(got_n[0]), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_word%0d_w16", i), got[0][i], 64'(16'hA000 + i));
    chk("t1_last_idx_w16", 64'(got_last_idx[0]), 64'd15);
    chk("t1_count_w64", 64'(got_n[2]), 64'd4);
    chk("t1_word0_w64", got[2][0], 64'hA000A001A002A003);

    // 224-bit digest, partial final 64-bit word
    state_in = '1;
    state_in[1599 -: 256] = {{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}};
    start(2'b00);
    run_idle("t2", 1'b0);
    chk("t2_count_w64", 64'(got_n[2]), 64'd4);
    chk("t2_word0_w64", got[2][0], 64'h1111111111111111);
    chk("t2_word3_w64", got[2][3], 64'h4444444400000000);
    chk("t2_last_idx_w64", 64'(got_last_idx[2]), 64'd3);
    chk("t2_count_w16", 64'(got_n[0]), 64'd14);
    chk("t2_word13_w16", got[0][13], 64'h4444);
    chk("t2_count_w32", 64'(got_n[1]), 64'd7);
    chk("t2_word6_w32", got[1][6], 64'h44444444);

    // 512-bit digest with ready toggling 1,0,1,0
    state_in = {400{4'h9}};
    for (int i = 0; i < 16; i++) state_in[1599-32*i -: 32] = 32'(32'hC0DE0000 + i);
    start(2'b11);
    m_ready = 1'b1;
    run_idle("t3", 1'b1);
    chk("t3_count_w32", 64'(got_n[1]), 64'd16);
    chk("t3_word0_w32", got[1][0], 64'hC0DE0000);
    chk("t3_word7_w32", got[1][7], 64'hC0DE0007);
    chk("t3_word15_w32", got[1][15], 64'hC0DE000F);
    chk("t3_last_idx_w32", 64'(got_last_idx[1]), 64'd15);
    chk("t3_count_w16", 64'(got_n[0]), 64'd32);
    chk("t3_word1_w16", got[0][1], 64'h0000);
    chk("t3_word2_w16", got[0][2], 64'hC0DE);

    // reset after the third transfer aborts, next digest restarts at word 0
    pat_a(); m_ready = 1'b1;
    start(2'b01);
    tick(); tick(); tick();
    chk("t4_count_before_rst_w16", 64'(got_n[0]), 64'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("t4_valid_after_rst_w16", 64'(dvalid[0]), 64'd0);
    chk("t4_ready_after_rst_w16", 64'(dready[0]), 64'd1);
    chk("t4_ready_after_rst_w64", 64'(dready[2]), 64'd1);
    chk("t4_count_at_rst_w16", 64'(got_n[0]), 64'd3);
    start(2'b01);
    run_idle("t4", 1'b0);
    chk("t4_count_w16", 64'(got_n[0]), 64'd16);
    chk("t4_word0_w16", got[0][0], 64'hA000);
    chk("t4_word15_w16", got[0][15], 64'hA00F);

    // new state offered during SEND is ignored
    pat_a(); m_ready = 1'b1;
    start(2'b01);
    tick();
    state_in = '1; mode = 2'b11; state_valid = 1'b1;
    tick(); tick();
    state_valid = 1'b0; mode = 2'b01;
    run_idle("t5", 1'b0);
    chk("t5_count_w16", 64'(got_n[0]), 64'd16);
    chk("t5_word1_w16", got[0][1], 64'hA001);
    chk("t5_word15_w16", got[0][15], 64'hA00F);
    chk("t5_last_idx_w16", 64'(got_last_idx[0]), 64'd15);
    chk("t5_count_w64", 64'(got_n[2]), 64'd4);
    chk("t5_word3_w64", got[2][3], 64'hA00CA00DA00EA00F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sha3_digest_serializer.md
SHA3_DIGEST_SERIALIZER -- requirements
Module: sha3_digest_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, output word width in bits; legal values are 16, 32 and 64.
REQ-002 clk  input  1  clock; all logic updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 state_in  input  1600  final Keccak state; bit 1599 is the first bit emitted.
REQ-005 state_valid  input  1  state_in and mode are offered for capture.
REQ-006 state_ready  output  1  block can capture a new state this cycle.
REQ-007 mode  input  2  digest length select: 00=224, 01=256, 10=384, 11=512 bits.
REQ-008 m_data  output  DATA_WIDTH  current output word.
REQ-009 m_valid  output  1  m_data holds a valid digest word.
REQ-010 m_ready  input  1  downstream accepts m_data this cycle.
REQ-011 m_last  output  1  current word is the final word of the digest.
REQ-012 busy  output  1  a digest is being emitted (high in SEND).

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 In IDLE, state_ready SHALL be 1 and m_valid SHALL be 0.
REQ-015 In IDLE, state_valid=1 SHALL load state_in into a 1600-bit shift register, latch mode, load the word counter, and move the FSM to SEND on the next edge.
REQ-016 Word count SHALL be ceil(digest_bits/DATA_WIDTH): 224 gives 14/7/4, 256 gives 16/8/4, 384 gives 24/12/6, 512 gives 32/16/8 words for DATA_WIDTH 16/32/64.
REQ-017 In SEND, m_valid SHALL be 1, state_ready SHALL be 0, and m_data SHALL equal shift register bits [1599 -: DATA_WIDTH].
REQ-018 Latency: m_valid SHALL first assert in the cycle after the capture handshake.
REQ-019 A transfer occurs when m_valid and m_ready are both 1; the register then SHALL shift left by DATA_WIDTH (zero fill) and the counter SHALL decrement.
REQ-020 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable, and no shift or decrement SHALL occur.
REQ-021 m_last SHALL be 1 exactly when the counter indicates the final word.
REQ-022 A transfer with m_last=1 SHALL return the FSM to IDLE, so state_ready=1 in the next cycle; there is one idle cycle minimum between digests.
REQ-023 For a partial final word (224-bit digest with DATA_WIDTH=64), m_data SHALL carry the digest bits in its MSBs and zeros in the unused LSBs (lower 32 bits zero).
REQ-024 state_valid, state_in and mode SHALL be ignored during SEND.
REQ-025 Bits of state_in beyond the digest length SHALL never appear on m_data.

Reset
REQ-026 While RST=1, the FSM SHALL go to IDLE, the shift register, counter and latched mode SHALL clear to 0, and m_valid, m_last and busy SHALL be 0.
REQ-027 state_ready SHALL be 0 during any cycle in which RST=1, and 1 from the first cycle after RST deasserts.
REQ-028 RST during SEND SHALL abort the digest with no further words emitted; the next capture SHALL start from word 0.
REQ-029 RST SHALL take priority over simultaneous state_valid or m_ready.

Structure
REQ-030 Package sha3_pkg SHALL hold: constant STATE_WIDTH=1600, enum sha3_mode_t for the four mode encodings, and a function returning digest bits per mode.
REQ-031 The word-count computation SHALL use sha3_pkg and DATA_WIDTH only, with no per-width hardcoded tables in the module.
REQ-032 No sub-module is needed; the FSM, shift register and counter live in sha3_digest_serializer.

Verification
REQ-033 DATA_WIDTH=16, mode=01, top 16 words of state_in = 16'hA000..16'hA00F, m_ready=1 -> exactly 16 words A000..A00F on consecutive cycles, m_last on A00F, state_ready=1 the following cycle.
REQ-034 DATA_WIDTH=64, mode=00, top 256 bits = 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... -> 4 words, fourth word = 64'h44444444_00000000 with m_last=1.
REQ-035 DATA_WIDTH=32, mode=11, m_ready toggling 1,0,1,0 -> 16 words in order, m_data held stable on stall cycles, no word duplicated or dropped.
REQ-036 RST pulsed for 1 cycle after the 3rd transfer of a 256-bit/16-bit digest -> next cycle m_valid=0 and state_ready=1; a new capture then emits from word 0.
REQ-037 During SEND, state_valid=1 with a different state_in and mode=11 -> output unchanged from the original digest and word count, with no extra words.
